song_playback_sequencer: RTL and testbench

//  Consumer of the 5-bit state word driven by the music box state controller.
//  On state PlaySong0 (5'd1) or PlaySong1 (5'd2): steps through an internal note ROM, one key code per note.

---
 rtl/song_playback_sequencer_if.sv | 27 ++
 rtl/song_playback_sequencer.sv | 127 ++++++++++++
 tb/tb_song_playback_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/song_playback_sequencer_if.sv
// Bundle between the music box state controller and the song playback sequencer.
interface song_playback_sequencer_if;
    logic [4:0] input_State;
    logic [5:0] output_NoteKey;
    logic       output_NoteValid;
    logic       output_SongDone;
    logic       output_Busy;
    logic [3:0] output_NoteIndex;

    modport master (
        output input_State,
        input  output_NoteKey,
        input  output_NoteValid,
        input  output_SongDone,
        input  output_Busy,
        input  output_NoteIndex
    );

    modport slave (
        input  input_State,
        output output_NoteKey,
        output output_NoteValid,
        output output_SongDone,
        output output_Busy,
        output output_NoteIndex
    );
endinterface

// File: rtl/song_playback_sequencer.sv
// Plays a song from an internal note ROM while the controller holds PlaySong0/PlaySong1,
// timing each note and inter-note gap in duration ticks and pulsing SongDone at the terminator.
module song_playback_sequencer #(
    parameter int unsigned TICK_DIV = 3125000
) (
    input logic                      clock_50Mhz,
    input logic                      reset_n,
    song_playback_sequencer_if.slave bus
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} state_t;

    state_t        state_q;
    state_t        state_d;
    logic [TW-1:0] tick_cnt_q;
    logic [3:0]    dur_cnt_q;
    logic [3:0]    index_q;
    logic [5:0]    key_q;
    logic [4:0]    song_state_q;
    logic          done_seen_q;
    logic          tick;
    logic          state_changed;
    logic          song_req;
    logic [9:0]    rom_entry;

    // Entry layout {key[5:0], dur[3:0]}; dur==0 terminates the song.
    function automatic logic [9:0] rom_read(input logic song_sel, input logic [3:0] idx);
        logic [9:0] e;
        e = '0;
        if (!song_sel) begin
            case (idx)
                4'd0:    e = {6'd5, 4'd2};
                4'd1:    e = {6'd7, 4'd2};
                4'd2:    e = {6'd9, 4'd4};
                default: e = '0;
            endcase
        end else begin
            case (idx)
                4'd0:    e = {6'd12, 4'd1};
                4'd1:    e = {6'd10, 4'd1};
                4'd2:    e = {6'd8,  4'd1};
                4'd3:    e = {6'd7,  4'd3};
                default: e = '0;
            endcase
        end
        return e;
    endfunction

    assign tick          = (tick_cnt_q == TICK_LAST);
    assign state_changed = (bus.input_State != song_state_q);
    assign song_req      = (bus.input_State == 5'd1) || (bus.input_State == 5'd2);
    assign rom_entry     = rom_read(song_state_q == 5'd2, index_q);

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (song_req) state_d = LOAD;
            LOAD: begin
                if (state_changed)               state_d = IDLE;
                else if (rom_entry[3:0] == 4'd0) state_d = DONE;
                else                             state_d = PLAY;
            end
            PLAY: begin
                if (state_changed)                   state_d = IDLE;
                else if (tick && dur_cnt_q == 4'd1)  state_d = GAP;
            end
            GAP: begin
                if (state_changed)  state_d = IDLE;
                else if (tick)      state_d = (index_q == 4'd15) ? DONE : LOAD;
            end
            DONE: if (state_changed) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q   <= '0;
            dur_cnt_q    <= '0;
            index_q      <= '0;
            key_q        <= '0;
            song_state_q <= '0;
            done_seen_q  <= 1'b0;
        end else begin
            done_seen_q <= (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (state_d == LOAD) begin
                        song_state_q <= bus.input_State;
                        index_q      <= '0;
                    end
                end
                LOAD: begin
                    key_q     <= rom_entry[9:4];
                    dur_cnt_q <= rom_entry[3:0];
                end
                PLAY: if (tick) dur_cnt_q <= dur_cnt_q - 4'd1;
                GAP:  if (state_d == LOAD) index_q <= index_q + 4'd1;
                default: ;
            endcase
            // Tick phase restarts at every note so each note and gap gets whole ticks.
            if (state_q == PLAY || state_q == GAP) begin
                tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
            end else begin
                tick_cnt_q <= '0;
            end
        end
    end

    assign bus.output_NoteValid = (state_q == PLAY);
    assign bus.output_NoteKey   = (state_q == PLAY) ? key_q : 6'd0;
    assign bus.output_Busy      = (state_q == LOAD) || (state_q == PLAY) || (state_q == GAP);
    assign bus.output_SongDone  = (state_q == DONE) && !done_seen_q;
    assign bus.output_NoteIndex = index_q;

endmodule

// File: tb/tb_song_playback_sequencer.sv
// Scoreboard bench for song_playback_sequencer with TICK_DIV=4.
module tb_song_playback_sequencer;

    localparam int EV_RISE = 0;
    localparam int EV_NOTE = 1;
    localparam int EV_DONE = 2;

    typedef struct {
        int kind;
        int key;
        int idx;
        int len;
    } ev_t;

    logic clock_50Mhz;
    logic reset_n;
    int   checks;
    int   failures;
    ev_t  exp_q[$];

    song_playback_sequencer_if bus();

    song_playback_sequencer #(.TICK_DIV(4)) dut (
        .clock_50Mhz(clock_50Mhz),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial begin
        clock_50Mhz = 1'b0;
        forever #5 clock_50Mhz = ~clock_50Mhz;
    end

    function automatic string kname(input int k);
        case (k)
            EV_RISE: return "note_start";
            EV_NOTE: return "note_end";
            default: return "song_done";
        endcase
    endfunction

    task automatic push(input int kind, input int key, input int idx, input int len);
        ev_t e;
        e.kind = kind; e.key = key; e.idx = idx; e.len = len;
        exp_q.push_back(e);
    endtask

    // low_len for note_start is the count of busy-but-silent cycles before the note
    task automatic push_song0();
        push(EV_RISE, 5, 0, 1);  push(EV_NOTE, 5, 0, 8);
        push(EV_RISE, 7, 1, 5);  push(EV_NOTE, 7, 1, 8);
        push(EV_RISE, 9, 2, 5);  push(EV_NOTE, 9, 2, 16);
        push(EV_DONE, 0, 3, 5);
    endtask

    task automatic push_song1();
        push(EV_RISE, 12, 0, 1); push(EV_NOTE, 12, 0, 4);
        push(EV_RISE, 10, 1, 5); push(EV_NOTE, 10, 1, 4);
        push(EV_RISE, 8, 2, 5);  push(EV_NOTE, 8, 2, 4);
        push(EV_RISE, 7, 3, 5);  push(EV_NOTE, 7, 3, 12);
        push(EV_DONE, 0, 4, 5);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic match(input int kind, input int key, input int idx, input int len);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_%s actual key=%0d idx=%0d len=%0d required=no event",
                     kname(kind), key, idx, len);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.key != key || e.idx != idx || e.len != len) begin
                failures++;
                $display("FAIL event actual=%s key=%0d idx=%0d len=%0d required=%s key=%0d idx=%0d len=%0d",
                         kname(kind), key, idx, len, kname(e.kind), e.key, e.idx, e.len);
            end
        end
    endtask

    // Monitor: compresses the output stream into note/gap/done events.
    int mon_pv, mon_len, mon_key, mon_idx, mon_low;
    initial begin
        mon_pv = 0; mon_len = 0; mon_key = 0; mon_idx = 0; mon_low = 0;
    end

    always @(negedge clock_50Mhz) begin
        int v, k, ix, b, d;
        v  = int'(bus.output_NoteValid);
        k  = int'(bus.output_NoteKey);
        ix = int'(bus.output_NoteIndex);
        b  = int'(bus.output_Busy);
        d  = int'(bus.output_SongDone);
        if (!reset_n) begin
            mon_pv = 0; mon_len = 0; mon_low = 0;
        end else begin
            if (v == 0 && k != 0) chk("key_zero_when_silent", k, 0);
            if (v != 0 && mon_pv == 0) begin
                match(EV_RISE, k, ix, mon_low);
                mon_len = 1; mon_key = k; mon_idx = ix; mon_low = 0;
            end else if (v != 0) begin
                mon_len++;
                if (k != mon_key) chk("key_stable_in_note", k, mon_key);
            end else if (mon_pv != 0) begin
                match(EV_NOTE, mon_key, mon_idx, mon_len);
                mon_low = 0;
            end
            if (d != 0) begin
                match(EV_DONE, 0, ix, mon_low);
                mon_low = 0;
            end else if (b == 0) begin
                mon_low = 0;
            end else if (v == 0) begin
                mon_low++;
            end
            mon_pv = v;
        end
    end

    task automatic wait_note(input int key, input int bound);
        int n;
        n = 0;
        do begin
            @(negedge clock_50Mhz);
            n++;
        end while (!(bus.output_NoteValid && int'(bus.output_NoteKey) == key) && n < bound);
        if (!(bus.output_NoteValid && int'(bus.output_NoteKey) == key)) begin
            checks++; failures++;
            $display("FAIL timeout_note_%0d actual=not seen required=seen within %0d cycles", key, bound);
        end
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        do begin
            @(negedge clock_50Mhz);
            n++;
        end while (!bus.output_SongDone && n < bound);
        if (!bus.output_SongDone) begin
            checks++; failures++;
            $display("FAIL timeout_song_done actual=not seen required=seen within %0d cycles", bound);
        end
    endtask

    task automatic idle_gap();
        bus.input_State = 5'd0;
        repeat (3) @(negedge clock_50Mhz);
    endtask

    initial begin
        logic [4:0] inv_states [3];
        int         bad;
        checks = 0;
        failures = 0;
        inv_states[0] = 5'd3; inv_states[1] = 5'd4; inv_states[2] = 5'd8;
        reset_n = 1'b0;
        bus.input_State = 5'd1;

        // Reset holds everything at zero even with a song requested
        repeat (3) @(negedge clock_50Mhz);
        chk("reset_valid", int'(bus.output_NoteValid), 0);
        chk("reset_key",   int'(bus.output_NoteKey), 0);
        chk("reset_busy",  int'(bus.output_Busy), 0);
        chk("reset_done",  int'(bus.output_SongDone), 0);
        chk("reset_index", int'(bus.output_NoteIndex), 0);
        bus.input_State = 5'd0;
        #2 reset_n = 1'b1;
        repeat (2) @(negedge clock_50Mhz);

        foreach (inv_states[i]) begin
            bus.input_State = inv_states[i];
            bad = 0;
            repeat (20) begin
                @(negedge clock_50Mhz);
                if (bus.output_NoteValid || bus.output_NoteKey != 0 || bus.output_Busy ||
                    bus.output_SongDone || bus.output_NoteIndex != 0) bad++;
            end
            chk($sformatf("invalid_state_%0d_active_cycles", inv_states[i]), bad, 0);
        end
        idle_gap();

        // Song0, state held after completion
        push_song0();
        bus.input_State = 5'd1;
        wait_done(200);
        bad = 0;
        repeat (20) begin
            @(negedge clock_50Mhz);
            if (bus.output_Busy || bus.output_SongDone || bus.output_NoteValid) bad++;
        end
        chk("song0_hold_active_cycles", bad, 0);
        idle_gap();

        // Song1 twice, with a return to DoNothing between runs
        push_song1();
        bus.input_State = 5'd2;
        wait_done(200);
        idle_gap();
        push_song1();
        bus.input_State = 5'd2;
        wait_done(200);
        idle_gap();

        // Abort during key7
        push(EV_RISE, 5, 0, 1); push(EV_NOTE, 5, 0, 8); push(EV_RISE, 7, 1, 5);
        bus.input_State = 5'd1;
        wait_note(7, 60);
        repeat (2) @(negedge clock_50Mhz);
        push(EV_NOTE, 7, 1, 3);
        bus.input_State = 5'd0;
        @(negedge clock_50Mhz);
        chk("abort_valid", int'(bus.output_NoteValid), 0);
        chk("abort_key",   int'(bus.output_NoteKey), 0);
        chk("abort_busy",  int'(bus.output_Busy), 0);
        bad = 0;
        repeat (30) begin
            @(negedge clock_50Mhz);
            if (bus.output_SongDone || bus.output_Busy) bad++;
        end
        chk("abort_no_done_cycles", bad, 0);

        // Direct switch song0 -> song1 mid-note
        push(EV_RISE, 5, 0, 1);
        bus.input_State = 5'd1;
        wait_note(5, 20);
        repeat (2) @(negedge clock_50Mhz);
        push(EV_NOTE, 5, 0, 3);
        push_song1();
        bus.input_State = 5'd2;
        @(negedge clock_50Mhz);
        chk("switch_idle_busy",  int'(bus.output_Busy), 0);
        chk("switch_idle_valid", int'(bus.output_NoteValid), 0);
        @(negedge clock_50Mhz);
        chk("switch_load_busy",  int'(bus.output_Busy), 1);
        chk("switch_load_valid", int'(bus.output_NoteValid), 0);
        @(negedge clock_50Mhz);
        chk("switch_play_valid", int'(bus.output_NoteValid), 1);
        chk("switch_play_key",   int'(bus.output_NoteKey), 12);
        wait_done(200);
        idle_gap();

        // Asynchronous reset in the middle of key7
        push(EV_RISE, 5, 0, 1); push(EV_NOTE, 5, 0, 8); push(EV_RISE, 7, 1, 5);
        bus.input_State = 5'd1;
        wait_note(7, 60);
        @(negedge clock_50Mhz);
        #2 reset_n = 1'b0;
        #1;
        chk("areset_valid", int'(bus.output_NoteValid), 0);
        chk("areset_key",   int'(bus.output_NoteKey), 0);
        chk("areset_busy",  int'(bus.output_Busy), 0);
        chk("areset_done",  int'(bus.output_SongDone), 0);
        chk("areset_index", int'(bus.output_NoteIndex), 0);
        @(negedge clock_50Mhz);
        bus.input_State = 5'd0;
        #3 reset_n = 1'b1;
        @(negedge clock_50Mhz);
        push_song0();
        bus.input_State = 5'd1;
        wait_done(200);
        idle_gap();

        repeat (5) @(negedge clock_50Mhz);
        chk("expected_events_left", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
